// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry add/subtract with one W-bit slice per stage.
// The carry ripples one slice per cycle under a global valid/ready stall.
module pipelined_ripple_adder #(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         carry_out,
    output logic         overflow
);

    localparam int W = N / STAGES;

    logic adv;

    logic [N-1:0] a_q [STAGES];
    logic [N-1:0] b_q [STAGES];
    logic [N-1:0] s_q [STAGES];
    logic         c_q [STAGES];
    logic         m_q [STAGES];
    logic         v_q [STAGES];

    logic [N-1:0] a_n [STAGES];
    logic [N-1:0] b_n [STAGES];
    logic [N-1:0] s_n [STAGES];
    logic         c_n [STAGES];
    logic         m_n [STAGES];
    logic         v_n [STAGES];

    logic [N-1:0] ta;
    logic [N-1:0] tb;
    logic [N-1:0] ts;
    logic         tc;
    logic         tm;
    logic         tx;
    int           p;

    assign adv       = ~v_q[STAGES-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry_out = c_q[STAGES-1];
    assign overflow  = c_q[STAGES-1] ^ m_q[STAGES-1];

    // Slice r takes its operands/carry from stage r-1, or from the ports for r=0.
    always_comb begin
        ta = '0;
        tb = '0;
        ts = '0;
        tc = 1'b0;
        tm = 1'b0;
        tx = 1'b0;
        p  = 0;
        for (int r = 0; r < STAGES; r++) begin
            p = (r > 0) ? r - 1 : 0;
            if (r == 0) begin
                ta = a;
                tb = sub ? ~b : b;
                ts = '0;
                tc = sub | carry_in;
                v_n[r] = in_valid;
            end else begin
                ta = a_q[p];
                tb = b_q[p];
                ts = s_q[p];
                tc = c_q[p];
                v_n[r] = v_q[p];
            end
            tm = 1'b0;
            for (int j = 0; j < W; j++) begin
                tx = ta[r*W+j] ^ tb[r*W+j];
                ts[r*W+j] = tx ^ tc;
                if (r*W + j == N - 1) tm = tc;
                tc = (ta[r*W+j] & tb[r*W+j]) | (tx & tc);
            end
            a_n[r] = ta;
            b_n[r] = tb;
            s_n[r] = ts;
            c_n[r] = tc;
            m_n[r] = tm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < STAGES; r++) begin
                a_q[r] <= '0;
                b_q[r] <= '0;
                s_q[r] <= '0;
                c_q[r] <= 1'b0;
                m_q[r] <= 1'b0;
                v_q[r] <= 1'b0;
            end
        end else if (adv) begin
            for (int r = 0; r < STAGES; r++) begin
                a_q[r] <= a_n[r];
                b_q[r] <= b_n[r];
                s_q[r] <= s_n[r];
                c_q[r] <= c_n[r];
                m_q[r] <= m_n[r];
                v_q[r] <= v_n[r];
            end
        end
    end

endmodule
